// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Fetch stage with a one-request-at-a-time imem port, a PC/insn
//            FIFO presented to decode, HLT stop and commit-side redirect.
//            Optional macro FETCH_BRANCH_PREDICT_EN: predict B/BL targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;
  typedef struct packed {
    logic        done;
    logic [31:0] insnbits;
    logic [63:0] pc;
  } fetch_interface;
endpackage

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic           in_clk,
  input  logic           in_rst,
  output logic           out_imem_req,
  output logic [63:0]    out_imem_addr,
  input  logic           in_imem_valid,
  input  logic [31:0]    in_imem_insnbits,
  input  logic           in_stall,
  input  logic           in_redirect,
  input  logic [63:0]    in_redirect_pc,
  output fetch_interface out_fetch_sigs,
  output logic           out_halted
);

  localparam int c_ptr_w = $clog2(QUEUE_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(QUEUE_DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_p_one = c_ptr_w'(1);

  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_drop  = 2'd2;
  localparam logic [1:0] c_st_halt  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [63:0]        r_pc;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_mem_insn [QUEUE_DEPTH];
  logic [63:0]        r_mem_pc   [QUEUE_DEPTH];

  logic        w_empty;
  logic        w_full;
  logic        w_enq;
  logic        w_deq;
  logic        w_req;
  logic        w_is_hlt;
  logic [63:0] w_next_pc;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_depth);
  assign w_deq    = !w_empty && !in_stall && !in_redirect;
  assign w_enq    = (r_state == c_st_wait) && in_imem_valid && !in_redirect;
  assign w_is_hlt = (in_imem_insnbits[31:21] == 11'b11010100010) &&
                    (in_imem_insnbits[4:0] == 5'd0);

`ifdef FETCH_BRANCH_PREDICT_EN
  logic w_is_branch;
  assign w_is_branch = (in_imem_insnbits[31:26] == 6'b000101) ||
                       (in_imem_insnbits[31:26] == 6'b100101);
  assign w_next_pc = w_is_branch
                   ? r_pc + {{36{in_imem_insnbits[25]}}, in_imem_insnbits[25:0], 2'b00}
                   : r_pc + 64'd4;
`else
  assign w_next_pc = r_pc + 64'd4;
`endif

  // Redirect outranks everything; a redirect while a response is still in
  // flight must swallow that stale word, hence DROP.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    if (in_redirect) begin
      case (r_state)
        c_st_wait: w_state_nxt = in_imem_valid ? c_st_fetch : c_st_drop;
        c_st_drop: w_state_nxt = c_st_drop;
        default:   w_state_nxt = c_st_fetch;
      endcase
    end else begin
      case (r_state)
        c_st_fetch: begin
          if (!w_full) begin
            w_req       = 1'b1;
            w_state_nxt = c_st_wait;
          end
        end
        c_st_wait: begin
          if (in_imem_valid) w_state_nxt = w_is_hlt ? c_st_halt : c_st_fetch;
        end
        c_st_drop: begin
          if (in_imem_valid) w_state_nxt = c_st_fetch;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state  <= c_st_fetch;
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (in_redirect) begin
        r_pc     <= in_redirect_pc;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) begin
          r_pc     <= w_next_pc;
          r_wr_ptr <= r_wr_ptr + c_p_one;
        end
        if (w_deq) r_rd_ptr <= r_rd_ptr + c_p_one;
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + c_one;
          2'b01:   r_count <= r_count - c_one;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge in_clk) begin
    if (w_enq) begin
      r_mem_insn[r_wr_ptr] <= in_imem_insnbits;
      r_mem_pc[r_wr_ptr]   <= r_pc;
    end
  end

  assign out_imem_req            = w_req && !in_rst;
  assign out_imem_addr           = r_pc;
  assign out_halted              = (r_state == c_st_halt);
  assign out_fetch_sigs.done     = w_deq;
  assign out_fetch_sigs.insnbits = w_empty ? 32'd0 : r_mem_insn[r_rd_ptr];
  assign out_fetch_sigs.pc       = w_empty ? 64'd0 : r_mem_pc[r_rd_ptr];

`ifndef SYNTHESIS
  always @(posedge in_clk) begin
    if (!in_rst) assert (!(w_enq && w_full));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: straight line, full FIFO, branch, redirect,
// HLT and asynchronous reset.
`default_nettype none

module tb_fetch_queue;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'hD503201F;
  localparam logic [31:0] HLT = 32'hD4400000;

  logic           in_clk = 1'b0;
  logic           in_rst = 1'b0;
  logic           out_imem_req;
  logic [63:0]    out_imem_addr;
  logic           in_imem_valid = 1'b0;
  logic [31:0]    in_imem_insnbits = '0;
  logic           in_stall = 1'b0;
  logic           in_redirect = 1'b0;
  logic [63:0]    in_redirect_pc = '0;
  fetch_interface out_fetch_sigs;
  logic           out_halted;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(64'h1000)) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .out_imem_req    (out_imem_req),
    .out_imem_addr   (out_imem_addr),
    .in_imem_valid   (in_imem_valid),
    .in_imem_insnbits(in_imem_insnbits),
    .in_stall        (in_stall),
    .in_redirect     (in_redirect),
    .in_redirect_pc  (in_redirect_pc),
    .out_fetch_sigs  (out_fetch_sigs),
    .out_halted      (out_halted)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic v, input logic [31:0] w, input logic st,
                     input logic rd, input logic [63:0] rpc);
    in_imem_valid    = v;
    in_imem_insnbits = w;
    in_stall         = st;
    in_redirect      = rd;
    in_redirect_pc   = rpc;
    #1;
  endtask

  task automatic nxt();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    set(0, 0, 0, 0, 0);
    in_rst = 1'b1;
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  // Request cycle in FETCH followed by a 1-cycle response in WAIT.
  task automatic fetch(input logic [63:0] a, input logic [31:0] w, input logic st);
    set(0, 0, st, 0, 0);
    chk("req", {63'd0, out_imem_req}, 64'd1);
    chk("addr", out_imem_addr, a);
    nxt();
    set(1, w, st, 0, 0);
    chk("req_in_wait", {63'd0, out_imem_req}, 64'd0);
    nxt();
  endtask

  initial begin
    // Reset values, asserted between edges
    #2 in_rst = 1'b1;
    #1;
    chk("rst_req", {63'd0, out_imem_req}, 64'd0);
    chk("rst_done", {63'd0, out_fetch_sigs.done}, 64'd0);
    chk("rst_insn", {32'd0, out_fetch_sigs.insnbits}, 64'd0);
    chk("rst_pc", out_fetch_sigs.pc, 64'd0);
    chk("rst_halted", {63'd0, out_halted}, 64'd0);
    chk("rst_addr", out_imem_addr, 64'h1000);

    // Straight line
    do_reset();
    fetch(64'h1000, NOP, 0);
    chk("sl_done0", {63'd0, out_fetch_sigs.done}, 64'd1);
    chk("sl_pc0", out_fetch_sigs.pc, 64'h1000);
    fetch(64'h1004, NOP, 0);
    chk("sl_pc1", out_fetch_sigs.pc, 64'h1004);
    fetch(64'h1008, NOP, 0);
    chk("sl_pc2", out_fetch_sigs.pc, 64'h1008);
    chk("sl_insn2", {32'd0, out_fetch_sigs.insnbits}, {32'd0, NOP});

    // Full FIFO under stall
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fetch(64'h1000 + 64'(4 * k), NOP, 1);
      chk("full_done_stalled", {63'd0, out_fetch_sigs.done}, 64'd0);
    end
    set(0, 0, 1, 0, 0);
    chk("full_noreq0", {63'd0, out_imem_req}, 64'd0);
    nxt();
    set(0, 0, 1, 0, 0);
    chk("full_noreq1", {63'd0, out_imem_req}, 64'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("rel_done0", {63'd0, out_fetch_sigs.done}, 64'd1);
    chk("rel_pc0", out_fetch_sigs.pc, 64'h1000);
    chk("rel_noreq", {63'd0, out_imem_req}, 64'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("rel_pc1", out_fetch_sigs.pc, 64'h1004);
    chk("rel_req", {63'd0, out_imem_req}, 64'd1);
    chk("rel_addr", out_imem_addr, 64'h1010);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("rel_pc2", out_fetch_sigs.pc, 64'h1008);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("rel_pc3", out_fetch_sigs.pc, 64'h100C);
    chk("rel_done3", {63'd0, out_fetch_sigs.done}, 64'd1);
    nxt();
    set(1, NOP, 0, 0, 0);
    chk("rel_empty", {63'd0, out_fetch_sigs.done}, 64'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("rel_pc4", out_fetch_sigs.pc, 64'h1010);
    chk("rel_addr2", out_imem_addr, 64'h1014);

    // Branch B -4 at 0x1008
    do_reset();
    fetch(64'h1000, NOP, 0);
    fetch(64'h1004, NOP, 0);
    fetch(64'h1008, 32'h17FFFFFF, 0);
    set(0, 0, 0, 0, 0);
    chk("br_head", out_fetch_sigs.pc, 64'h1008);
    chk("br_req", {63'd0, out_imem_req}, 64'd1);
`ifdef FETCH_BRANCH_PREDICT_EN
    chk("br_target", out_imem_addr, 64'h1004);
`else
    chk("br_target", out_imem_addr, 64'h100C);
`endif

    // Redirect while a 3-cycle response is pending
    do_reset();
    fetch(64'h1000, NOP, 1);
    set(0, 0, 1, 0, 0);
    chk("rd_req", {63'd0, out_imem_req}, 64'd1);
    chk("rd_addr", out_imem_addr, 64'h1004);
    nxt();
    set(0, 0, 1, 0, 0);
    nxt();
    set(0, 0, 0, 1, 64'h2000);
    chk("rd_done_masked", {63'd0, out_fetch_sigs.done}, 64'd0);
    chk("rd_noreq", {63'd0, out_imem_req}, 64'd0);
    nxt();
    set(1, 32'hDEADBEEF, 0, 0, 0);
    chk("drop_noreq", {63'd0, out_imem_req}, 64'd0);
    chk("drop_empty", {63'd0, out_fetch_sigs.done}, 64'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("rd_new_req", {63'd0, out_imem_req}, 64'd1);
    chk("rd_new_addr", out_imem_addr, 64'h2000);
    chk("rd_stale_gone", {63'd0, out_fetch_sigs.done}, 64'd0);
    chk("rd_head_pc", out_fetch_sigs.pc, 64'd0);

    // HLT and restart by redirect
    do_reset();
    fetch(64'h1000, NOP, 0);
    fetch(64'h1004, HLT, 0);
    set(0, 0, 0, 0, 0);
    chk("hlt_halted", {63'd0, out_halted}, 64'd1);
    chk("hlt_done", {63'd0, out_fetch_sigs.done}, 64'd1);
    chk("hlt_insn", {32'd0, out_fetch_sigs.insnbits}, {32'd0, HLT});
    chk("hlt_pc", out_fetch_sigs.pc, 64'h1004);
    chk("hlt_noreq", {63'd0, out_imem_req}, 64'd0);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("hlt_noreq2", {63'd0, out_imem_req}, 64'd0);
    nxt();
    set(0, 0, 0, 1, 64'h3000);
    chk("hlt_still", {63'd0, out_halted}, 64'd1);
    nxt();
    set(0, 0, 0, 0, 0);
    chk("hlt_left", {63'd0, out_halted}, 64'd0);
    chk("hlt_req", {63'd0, out_imem_req}, 64'd1);
    chk("hlt_addr", out_imem_addr, 64'h3000);

    // Asynchronous reset with 3 entries queued
    do_reset();
    fetch(64'h1000, NOP, 1);
    fetch(64'h1004, NOP, 1);
    fetch(64'h1008, NOP, 1);
    set(0, 0, 0, 0, 0);
    chk("ar_done_pre", {63'd0, out_fetch_sigs.done}, 64'd1);
    chk("ar_req_pre", {63'd0, out_imem_req}, 64'd1);
    #2 in_rst = 1'b1;
    #1;
    chk("ar_done", {63'd0, out_fetch_sigs.done}, 64'd0);
    chk("ar_req", {63'd0, out_imem_req}, 64'd0);
    chk("ar_insn", {32'd0, out_fetch_sigs.insnbits}, 64'd0);
    @(posedge in_clk);
    #1 in_rst = 1'b0;
    set(0, 0, 0, 0, 0);
    chk("ar_first_req", {63'd0, out_imem_req}, 64'd1);
    chk("ar_first_addr", out_imem_addr, 64'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Fetch stage feeding decode. Holds the PC and issues one instruction-memory request at a time. Buffers returned instruction words with their PCs in a small FIFO, and presents the head to decode through `fetch_interface`. Applies a static taken-prediction for unconditional `B`/`BL`, stops after `HLT`, and restarts from a commit-side redirect after a mispredict.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, default 64'h0: PC loaded on reset.

Ports:
- `in_clk`, input, 1: clock.
- `in_rst`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `out_imem_req`, output, 1: request valid, high for exactly one cycle per request.
- `out_imem_addr`, output, 64: byte address of the request; equals the internal PC.
- `in_imem_valid`, input, 1: response valid. Arrives 1 or more cycles after the request.
- `in_imem_insnbits`, input, 32: instruction word, valid with `in_imem_valid`.
- `in_stall`, input, 1: decode cannot accept this cycle.
- `in_redirect`, input, 1: mispredict or restart from commit.
- `in_redirect_pc`, input, 64: new PC, valid with `in_redirect`.
- `out_fetch_sigs`, output, `fetch_interface`: `.done`, `.insnbits` (32), `.pc` (64). Head of the FIFO.
- `out_halted`, output, 1: high while in state HALT.

## Operation
State machine:
- **FETCH**
  - Request condition: `count + 1 <= QUEUE_DEPTH` (the slot reservation includes the request about to be outstanding).
  - If the condition holds: drive `out_imem_req=1` with `out_imem_addr=pc`, then go to WAIT.
  - If the condition fails: stay in FETCH with `out_imem_req=0`.
- **WAIT**
  - On `in_imem_valid`: enqueue `{insnbits, pc}` and update the PC (rules below).
  - Go to HALT if the word is `HLT`, otherwise to FETCH.
  - `HLT` match: `insnbits[31:21]==11'b11010100010` and `insnbits[4:0]==0`. The `HLT` word itself is enqueued.
- **DROP**
  - Entered when a redirect occurs in WAIT without a same-cycle response.
  - The next `in_imem_valid` word is discarded, then go to FETCH (the PC already holds the redirect target).
- **HALT**
  - No requests are issued.
  - Only a redirect leaves this state.

Next PC after a response:
- `B` (`[31:26]==6'b000101`) or `BL` (`6'b100101`): `pc + {{36{imm26[25]}}, imm26, 2'b00}`, computed modulo 2^64.
- Any other word: `pc + 4`.

Redirect (`in_redirect=1`, in any state, takes priority over every other event that cycle):
- FIFO is emptied (count=0, pointers=0) and `pc <= in_redirect_pc`.
- Any `in_imem_valid` in the same cycle is discarded.
- Next state:
  - WAIT with no same-cycle response → DROP.
  - WAIT with a same-cycle response → FETCH.
  - DROP → stays DROP.
  - FETCH → FETCH, and the same-cycle request is suppressed (`out_imem_req=0`).
  - HALT → FETCH.

Dequeue:
- `out_fetch_sigs.done = !empty && !in_stall && !in_redirect`.
- The head is popped on any cycle in which `.done` is high.
- `.insnbits` and `.pc` always show the head entry (0 when empty).

FIFO:
- Circular buffer; pointers wrap modulo `QUEUE_DEPTH`.
- Simultaneous enqueue and dequeue leaves count unchanged.
- Enqueue into a full FIFO cannot occur because of the slot reservation; an assertion checks this.

## Timing
Reset values, applied immediately on `in_rst` rise independent of `in_clk`:
- `pc=RESET_PC`, state FETCH, FIFO empty.
- `out_imem_req=0` while `in_rst` is high.
- `out_fetch_sigs.done=0`, `.insnbits=0`, `.pc=0`.
- `out_halted=0`.

Latencies:
- First request: the first cycle after reset deasserts.
- Response to `.done`: a response accepted at edge N is visible at the head after N. `.done` is high in cycle N+1 if that entry is at the head and `in_stall=0`.
- Back-to-back requests: with a 1-cycle imem, requests issue every 2 cycles (FETCH→WAIT→FETCH).
- Redirect: redirect at edge N. From FETCH, or from WAIT with a same-cycle response, the new request issues in cycle N+1. From DROP, or WAIT without a same-cycle response, it issues the cycle after the stale response arrives.
- `in_stall` is combinational into `.done` and has no latency.

Reset mid-operation:
- All state is lost.
- An outstanding imem response arriving after reset is ignored, because state is FETCH and responses are accepted only in WAIT/DROP.

## Configuration
- `FETCH_BRANCH_PREDICT_EN` defined: `B`/`BL` targets are predicted as above.
- `FETCH_BRANCH_PREDICT_EN` undefined: next PC is always `pc + 4`. `B`/`BL` are resolved by a later `in_redirect`.

## Test plan
- **Straight line:** reset with `RESET_PC=0x1000`, 1-cycle imem returning `NOP` (0xD503201F) → requests at 0x1000, 0x1004, 0x1008. `.done` pulses carry pc 0x1000, 0x1004, 0x1008 in order.
- **Full FIFO:** depth 4, `in_stall=1` → exactly 4 requests issue, then `out_imem_req` stays 0. Release the stall → 4 `.done` cycles in order, then fetching resumes at 0x1010.
- **Branch:** word 0x17FFFFFF (`B` -4) at 0x1008 → next request is 0x1004 with the macro defined, 0x100C without it.
- **Redirect during WAIT:** redirect to 0x2000 while a 3-cycle response is pending → stale word discarded, FIFO emptied, next request 0x2000.
- **HLT:** 0xD4400000 fetched at 0x1004 → enqueued and delivered, `out_halted=1`, no further requests. Redirect to 0x3000 → `out_halted=0`, request 0x3000.
- **Async reset mid-fill:** assert `in_rst` between clock edges with 3 entries queued → `.done=0` and `out_imem_req=0` immediately. After release the first request is at `RESET_PC`.
